// File: rtl/cpu_bus_arbiter.sv
// Shares one CPU memory bus between the instruction-fetch port and the load/store data port.
// Data wins by default; a starvation counter eventually forces a waiting fetch through.
module cpu_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_fetch_request,
  input  logic [31:0] i_fetch_address,
  output logic        o_fetch_ready,
  output logic [31:0] o_fetch_rdata,
  input  logic        i_data_request,
  input  logic        i_data_rw,
  input  logic [31:0] i_data_address,
  input  logic [31:0] i_data_wdata,
  input  logic [3:0]  i_data_byte_mask,
  output logic        o_data_ready,
  output logic [31:0] o_data_rdata,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_byte_mask,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata,
  output logic [1:0]  o_grant,
  output logic [31:0] o_starve_events
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_FETCH = 2'd1,
    GRANT_DATA  = 2'd2
  } state_t;

  localparam logic [7:0] LIMIT     = 8'(STARVE_LIMIT);
  localparam bit         STARVE_EN = (STARVE_LIMIT != 0);

  state_t      state_q, state_d;
  logic [7:0]  starve_q, starve_d;
  logic [31:0] starve_events_q, starve_events_d;
  logic        starve_hit;

  // Written as count+1 > limit so a zero limit never folds into a constant compare.
  assign starve_hit = STARVE_EN && (({1'b0, starve_q} + 9'd1) > {1'b0, LIMIT});

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q         <= IDLE;
      starve_q        <= 8'd0;
      starve_events_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      starve_q        <= starve_d;
      starve_events_q <= starve_events_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    starve_events_d = starve_events_q;
    case (state_q)
      IDLE: begin
        if (i_fetch_request && i_data_request) begin
          if (starve_hit) begin
            state_d         = GRANT_FETCH;
            starve_events_d = starve_events_q + 32'd1;
          end else begin
            state_d = GRANT_DATA;
          end
        end else if (i_fetch_request) begin
          state_d = GRANT_FETCH;
        end else if (i_data_request) begin
          state_d = GRANT_DATA;
        end
      end
      GRANT_FETCH: begin
        if (!i_fetch_request || i_bus_ready) state_d = IDLE;
      end
      GRANT_DATA: begin
        if (!i_data_request || i_bus_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Entering a fetch grant always clears the counter, even in the cycle it would count.
  always_comb begin
    starve_d = starve_q;
    if (state_d == GRANT_FETCH && state_q != GRANT_FETCH) begin
      starve_d = 8'd0;
    end else if (i_fetch_request && state_q != GRANT_FETCH && starve_q != 8'hff) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_comb begin
    o_bus_request   = 1'b0;
    o_bus_rw        = 1'b0;
    o_bus_address   = 32'd0;
    o_bus_wdata     = 32'd0;
    o_bus_byte_mask = 4'h0;
    o_fetch_ready   = 1'b0;
    o_fetch_rdata   = 32'd0;
    o_data_ready    = 1'b0;
    o_data_rdata    = 32'd0;
    case (state_q)
      GRANT_FETCH: begin
        o_bus_request   = i_fetch_request;
        o_bus_address   = i_fetch_address;
        o_bus_byte_mask = 4'hf;
        o_fetch_ready   = i_bus_ready && !i_reset;
        o_fetch_rdata   = i_bus_rdata;
      end
      GRANT_DATA: begin
        o_bus_request   = i_data_request;
        o_bus_rw        = i_data_rw;
        o_bus_address   = i_data_address;
        o_bus_wdata     = i_data_wdata;
        o_bus_byte_mask = i_data_byte_mask;
        o_data_ready    = i_bus_ready && !i_reset;
        o_data_rdata    = i_bus_rdata;
      end
      default: ;
    endcase
  end

  assign o_grant         = state_q;
  assign o_starve_events = starve_events_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: three instances (limits 16, 4, 0) driven from scripted cycle
// schedules; completions are matched against a queue of expected ready/rdata pairs.
module tb_cpu_bus_arbiter;

  logic        clk;
  logic        rst     [3];
  logic        f_req   [3];
  logic [31:0] f_addr  [3];
  logic        f_rdy   [3];
  logic [31:0] f_rdata [3];
  logic        d_req   [3];
  logic        d_rw    [3];
  logic [31:0] d_addr  [3];
  logic [31:0] d_wdata [3];
  logic [3:0]  d_mask  [3];
  logic        d_rdy   [3];
  logic [31:0] d_rdata [3];
  logic        b_req   [3];
  logic        b_rw    [3];
  logic [31:0] b_addr  [3];
  logic [31:0] b_wdata [3];
  logic [3:0]  b_mask  [3];
  logic        b_rdy   [3];
  logic [31:0] b_rdata [3];
  logic [1:0]  grant   [3];
  logic [31:0] events  [3];

  typedef struct {
    int          port;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  for (genvar g = 0; g < 3; g++) begin : u_gen
    cpu_bus_arbiter #(.STARVE_LIMIT((g == 0) ? 16 : (g == 1) ? 4 : 0)) dut (
      .i_clock         (clk),
      .i_reset         (rst[g]),
      .i_fetch_request (f_req[g]),
      .i_fetch_address (f_addr[g]),
      .o_fetch_ready   (f_rdy[g]),
      .o_fetch_rdata   (f_rdata[g]),
      .i_data_request  (d_req[g]),
      .i_data_rw       (d_rw[g]),
      .i_data_address  (d_addr[g]),
      .i_data_wdata    (d_wdata[g]),
      .i_data_byte_mask(d_mask[g]),
      .o_data_ready    (d_rdy[g]),
      .o_data_rdata    (d_rdata[g]),
      .o_bus_request   (b_req[g]),
      .o_bus_rw        (b_rw[g]),
      .o_bus_address   (b_addr[g]),
      .o_bus_wdata     (b_wdata[g]),
      .o_bus_byte_mask (b_mask[g]),
      .i_bus_ready     (b_rdy[g]),
      .i_bus_rdata     (b_rdata[g]),
      .o_grant         (grant[g]),
      .o_starve_events (events[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs(input int u);
    f_req[u] = 1'b0; f_addr[u] = 32'd0;
    d_req[u] = 1'b0; d_rw[u] = 1'b0; d_addr[u] = 32'd0; d_wdata[u] = 32'd0; d_mask[u] = 4'h0;
    b_rdy[u] = 1'b0; b_rdata[u] = 32'd0;
  endtask

  task automatic reset_unit(input int u);
    tick();
    rst[u] = 1'b1;
    clear_inputs(u);
    tick();
    tick();
    rst[u] = 1'b0;
  endtask

  task automatic push_exp(input int port, input logic [31:0] rdata);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic sample_ready(input int u, output int port, output logic [31:0] rd);
    port = (f_rdy[u] === 1'b1 ? 1 : 0) + (d_rdy[u] === 1'b1 ? 2 : 0);
    rd   = (d_rdy[u] === 1'b1) ? d_rdata[u] : f_rdata[u];
  endtask

  task automatic test_reset();
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1;
      clear_inputs(u);
    end
    tick();
    tick();
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      n_checks++;
      if (grant[u] !== 2'd0 || b_req[u] !== 1'b0 || f_rdy[u] !== 1'b0 || d_rdy[u] !== 1'b0 ||
          events[u] !== 32'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_state u%0d: grant=%0d bus_req=%b f_rdy=%b d_rdy=%b events=%0d, required all 0",
                 u, grant[u], b_req[u], f_rdy[u], d_rdy[u], events[u]);
      end
    end
    for (int u = 0; u < 3; u++) rst[u] = 1'b0;
  endtask

  task automatic test_fetch_only();
    int p; logic [31:0] rd; exp_t e;
    reset_unit(0);
    f_req[0] = 1'b1; f_addr[0] = 32'h100;
    @(negedge clk);
    n_checks++;
    if (grant[0] !== 2'd0 || b_req[0] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL fetch_latency: grant=%0d bus_req=%b, required 0/0", grant[0], b_req[0]);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (grant[0] !== 2'd1 || b_req[0] !== 1'b1 || b_addr[0] !== 32'h100 || b_rw[0] !== 1'b0 ||
        b_mask[0] !== 4'hf || b_wdata[0] !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL fetch_bus: grant=%0d req=%b addr=%h rw=%b mask=%h wdata=%h, required 1/1/100/0/f/0",
               grant[0], b_req[0], b_addr[0], b_rw[0], b_mask[0], b_wdata[0]);
    end
    tick();
    tick();
    tick();
    b_rdy[0] = 1'b1; b_rdata[0] = 32'hDEADBEEF;
    push_exp(1, 32'hDEADBEEF);
    @(negedge clk);
    sample_ready(0, p, rd);
    e = sb.pop_front();
    n_checks++;
    if (p !== e.port || rd !== e.rdata) begin
      n_fail++; $display("[TB] FAIL fetch_ready: port=%0d rdata=%h, required port=%0d rdata=%h", p, rd, e.port, e.rdata);
    end
    tick();
    b_rdy[0] = 1'b0; f_req[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (grant[0] !== 2'd0 || f_rdy[0] !== 1'b0 || f_rdata[0] !== 32'd0) begin
      n_fail++; $display("[TB] FAIL fetch_done: grant=%0d f_rdy=%b f_rdata=%h, required 0/0/0", grant[0], f_rdy[0], f_rdata[0]);
    end
  endtask

  task automatic test_priority();
    int p; logic [31:0] rd; exp_t e;
    reset_unit(0);
    f_req[0] = 1'b1; f_addr[0] = 32'h104;
    d_req[0] = 1'b1; d_rw[0] = 1'b1; d_addr[0] = 32'h200; d_wdata[0] = 32'h12345678; d_mask[0] = 4'b0011;
    tick();
    @(negedge clk);
    n_checks++;
    if (grant[0] !== 2'd2 || b_rw[0] !== 1'b1 || b_addr[0] !== 32'h200 || b_wdata[0] !== 32'h12345678 ||
        b_mask[0] !== 4'b0011) begin
      n_fail++;
      $display("[TB] FAIL data_priority: grant=%0d rw=%b addr=%h wdata=%h mask=%b, required 2/1/200/12345678/0011",
               grant[0], b_rw[0], b_addr[0], b_wdata[0], b_mask[0]);
    end
    tick();
    b_rdy[0] = 1'b1; b_rdata[0] = 32'hA5A5A5A5;
    push_exp(2, 32'hA5A5A5A5);
    @(negedge clk);
    sample_ready(0, p, rd);
    e = sb.pop_front();
    n_checks++;
    if (p !== e.port || rd !== e.rdata || f_rdata[0] !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL data_ready: port=%0d rdata=%h f_rdata=%h, required port=%0d rdata=%h f_rdata=0",
               p, rd, f_rdata[0], e.port, e.rdata);
    end
    tick();
    b_rdy[0] = 1'b0; d_req[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (grant[0] !== 2'd0) begin
      n_fail++; $display("[TB] FAIL gap_idle: grant=%0d, required 0", grant[0]);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (grant[0] !== 2'd1 || b_addr[0] !== 32'h104 || b_wdata[0] !== 32'd0 || b_rw[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL fetch_after_data: grant=%0d addr=%h wdata=%h rw=%b, required 1/104/0/0",
               grant[0], b_addr[0], b_wdata[0], b_rw[0]);
    end
    tick();
    b_rdy[0] = 1'b1; b_rdata[0] = 32'hCAFEF00D;
    push_exp(1, 32'hCAFEF00D);
    @(negedge clk);
    sample_ready(0, p, rd);
    e = sb.pop_front();
    n_checks++;
    if (p !== e.port || rd !== e.rdata || d_rdata[0] !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL fetch_ready2: port=%0d rdata=%h d_rdata=%h, required port=%0d rdata=%h d_rdata=0",
               p, rd, d_rdata[0], e.port, e.rdata);
    end
    tick();
    clear_inputs(0);
  endtask

  // Both requesters hold continuously; the bus answers in the first granted cycle.
  task automatic test_starvation();
    int seq [12] = '{0, 2, 0, 2, 0, 1, 0, 2, 0, 2, 0, 1};
    int p; logic [31:0] rd; exp_t e;
    reset_unit(1);
    f_req[1] = 1'b1; f_addr[1] = 32'h400;
    d_req[1] = 1'b1; d_rw[1] = 1'b0; d_addr[1] = 32'h500;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) tick();
      b_rdy[1]   = (seq[c] != 0);
      b_rdata[1] = 32'h1000 + 32'(c);
      if (seq[c] != 0) push_exp(seq[c], 32'h1000 + 32'(c));
      @(negedge clk);
      n_checks++;
      if (grant[1] !== 2'(seq[c])) begin
        n_fail++; $display("[TB] FAIL starve_grant c%0d: grant=%0d, required %0d", c, grant[1], seq[c]);
      end
      sample_ready(1, p, rd);
      if (p != 0) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("[TB] FAIL starve_ready c%0d: port=%0d, required no ready", c, p);
        end else begin
          e = sb.pop_front();
          if (p !== e.port || rd !== e.rdata) begin
            n_fail++;
            $display("[TB] FAIL starve_ready c%0d: port=%0d rdata=%h, required port=%0d rdata=%h", c, p, rd, e.port, e.rdata);
          end
        end
      end
      if (c == 6) begin
        n_checks++;
        if (events[1] !== 32'd1) begin
          n_fail++; $display("[TB] FAIL starve_events_first: events=%0d, required 1", events[1]);
        end
      end
    end
    n_checks++;
    if (events[1] !== 32'd2 || sb.size() != 0) begin
      n_fail++; $display("[TB] FAIL starve_events_final: events=%0d pending=%0d, required 2/0", events[1], sb.size());
    end
    sb.delete();
    tick();
    f_req[1] = 1'b0; d_req[1] = 1'b0; b_rdy[1] = 1'b0;
  endtask

  task automatic test_strict_data();
    int bad = 0;
    int data_done = 0;
    int p; logic [31:0] rd; exp_t e;
    reset_unit(2);
    f_req[2] = 1'b1; f_addr[2] = 32'h600;
    d_req[2] = 1'b1; d_rw[2] = 1'b0; d_addr[2] = 32'h700;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) tick();
      b_rdy[2]   = (c % 2 == 1);
      b_rdata[2] = 32'(c);
      if (c % 2 == 1) push_exp(2, 32'(c));
      @(negedge clk);
      if (grant[2] !== ((c % 2 == 1) ? 2'd2 : 2'd0)) bad++;
      sample_ready(2, p, rd);
      if (p != 0) begin
        if (sb.size() == 0) bad++;
        else begin
          e = sb.pop_front();
          if (p !== e.port || rd !== e.rdata) bad++;
          else data_done++;
        end
      end
    end
    n_checks++;
    if (bad != 0 || data_done != 100 || sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL strict_sequence: bad_cycles=%0d data_done=%0d pending=%0d, required 0/100/0",
               bad, data_done, sb.size());
    end
    n_checks++;
    if (events[2] !== 32'd0) begin
      n_fail++; $display("[TB] FAIL strict_events: events=%0d, required 0", events[2]);
    end
    sb.delete();
    tick();
    clear_inputs(2);
  endtask

  task automatic test_abort();
    reset_unit(0);
    d_req[0] = 1'b1; d_rw[0] = 1'b0; d_addr[0] = 32'h300;
    tick();
    @(negedge clk);
    n_checks++;
    if (grant[0] !== 2'd2 || b_req[0] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL abort_grant: grant=%0d bus_req=%b, required 2/1", grant[0], b_req[0]);
    end
    tick();
    d_req[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b_req[0] !== 1'b0 || d_rdy[0] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_drop: bus_req=%b d_rdy=%b, required 0/0", b_req[0], d_rdy[0]);
    end
    tick();
    b_rdy[0] = 1'b1; b_rdata[0] = 32'h77;
    @(negedge clk);
    n_checks++;
    if (grant[0] !== 2'd0 || d_rdy[0] !== 1'b0 || f_rdy[0] !== 1'b0 || d_rdata[0] !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL abort_idle: grant=%0d d_rdy=%b f_rdy=%b d_rdata=%h, required 0/0/0/0",
               grant[0], d_rdy[0], f_rdy[0], d_rdata[0]);
    end
    tick();
    clear_inputs(0);
  endtask

  // Reset lands while data holds the bus; the replay afterwards shows the counter restarted at 0.
  task automatic test_reset_mid();
    int seq [6] = '{0, 2, 0, 2, 0, 1};
    int p; logic [31:0] rd; exp_t e;
    tick();
    @(negedge clk);
    n_checks++;
    if (events[1] !== 32'd2) begin
      n_fail++; $display("[TB] FAIL pre_reset_events: events=%0d, required 2", events[1]);
    end
    tick();
    f_req[1] = 1'b1; f_addr[1] = 32'h800;
    d_req[1] = 1'b1; d_rw[1] = 1'b1; d_addr[1] = 32'h900; d_wdata[1] = 32'h55; d_mask[1] = 4'hf;
    tick();
    @(negedge clk);
    n_checks++;
    if (grant[1] !== 2'd2) begin
      n_fail++; $display("[TB] FAIL mid_grant: grant=%0d, required 2", grant[1]);
    end
    tick();
    rst[1] = 1'b1;
    tick();
    b_rdy[1] = 1'b1; b_rdata[1] = 32'hBAD;
    @(negedge clk);
    n_checks++;
    if (d_rdy[1] !== 1'b0 || grant[1] !== 2'd0 || b_req[1] !== 1'b0 || events[1] !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset: d_rdy=%b grant=%0d bus_req=%b events=%0d, required 0/0/0/0",
               d_rdy[1], grant[1], b_req[1], events[1]);
    end
    tick();
    rst[1] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      b_rdy[1]   = (seq[c] != 0);
      b_rdata[1] = 32'h2000 + 32'(c);
      if (seq[c] != 0) push_exp(seq[c], 32'h2000 + 32'(c));
      @(negedge clk);
      n_checks++;
      if (grant[1] !== 2'(seq[c])) begin
        n_fail++; $display("[TB] FAIL post_reset_grant c%0d: grant=%0d, required %0d", c, grant[1], seq[c]);
      end
      sample_ready(1, p, rd);
      if (p != 0) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("[TB] FAIL post_reset_ready c%0d: port=%0d, required no ready", c, p);
        end else begin
          e = sb.pop_front();
          if (p !== e.port || rd !== e.rdata) begin
            n_fail++;
            $display("[TB] FAIL post_reset_ready c%0d: port=%0d rdata=%h, required port=%0d rdata=%h",
                     c, p, rd, e.port, e.rdata);
          end
        end
      end
    end
    n_checks++;
    if (events[1] !== 32'd1 || sb.size() != 0) begin
      n_fail++; $display("[TB] FAIL post_reset_events: events=%0d pending=%0d, required 1/0", events[1], sb.size());
    end
    sb.delete();
    tick();
    clear_inputs(1);
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1;
      clear_inputs(u);
    end
    test_reset();
    test_fetch_only();
    test_priority();
    test_starvation();
    test_strict_data();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
